// File: rtl/ili9341_sequencer_pkg.sv
// Shared constants and types for the ILI9341 power-up / frame sequencer.
package ili9341_sequencer_pkg;

  // Command array select towards send_command
  localparam logic INI_COMM  = 1'b0;
  localparam logic LOOP_COMM = 1'b1;

  // Pin levels
  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RST_LOW   = 4'd1,
    ST_RST_WAIT  = 4'd2,
    ST_INIT_CMD  = 4'd3,
    ST_SLP_WAIT  = 4'd4,
    ST_LOOP_CMD  = 4'd5,
    ST_PIXELS    = 4'd6,
    ST_FRAME_END = 4'd7,
    ST_ERROR     = 4'd8
  } seq_state_t;

  // Larger of two cycle counts, used to size the shared delay counter
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ili9341_delay_timer.sv
// Loadable down-counter shared by the fixed delays and the handshake timeouts.
// Loading N-1 on state entry makes a state that exits on "expired" last N cycles.
module ili9341_delay_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt_reg;

  // Count down to zero and hold there; a load always wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Zero means the programmed interval has elapsed
  always_comb begin
    expired = (cnt_reg == '0);
  end

endmodule

// File: rtl/ili9341_sequencer.sv
// Power-up and per-frame scheduler for the ILI9341 SPI display path.
// Sequences panel reset, the init command array and the sleep-out delay,
// then loops: loop command array, pixel streaming, frame bookkeeping.
module ili9341_sequencer
  import ili9341_sequencer_pkg::*;
#(
  parameter int unsigned T_RST_LOW_CYC  = 10_000,
  parameter int unsigned T_RST_WAIT_CYC = 12_000_000,
  parameter int unsigned T_SLPOUT_CYC   = 12_000_000,
  parameter int unsigned TIMEOUT_CYC    = 50_000_000,
  parameter int          FCW            = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_reinit,
  output logic           o_lcd_rst_n,
  output logic           o_send_comm_ena,
  output logic           o_command,
  input  logic           i_comm_array_sent,
  output logic           o_pix_ena,
  input  logic           i_pix_done,
  output logic           o_busy,
  output logic           o_frame_done,
  output logic [FCW-1:0] o_frame_cnt,
  output logic           o_err
);

  // One counter serves every delay and every timeout, so size it for the longest
  localparam int unsigned MAX_CYC = max2(max2(T_RST_LOW_CYC, T_RST_WAIT_CYC),
                                         max2(T_SLPOUT_CYC, TIMEOUT_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LD_RST_LOW  = CW'(T_RST_LOW_CYC - 1);
  localparam logic [CW-1:0] LD_RST_WAIT = CW'(T_RST_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_SLPOUT   = CW'(T_SLPOUT_CYC - 1);
  localparam logic [CW-1:0] LD_TIMEOUT  = CW'(TIMEOUT_CYC - 1);

  seq_state_t     state_reg;
  seq_state_t     state_next;
  logic           init_done_reg;
  logic           reinit_pend_reg;
  logic           first_cycle_reg;
  logic [FCW-1:0] frame_cnt_reg;
  logic           err_reg;

  logic           state_change;
  logic           timer_load;
  logic [CW-1:0]  timer_val;
  logic           timer_expired;

  // Shared delay / timeout counter, reloaded on every state entry
  ili9341_delay_timer #(
    .CW (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; a handshake arriving on the last allowed cycle beats the timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = (init_done_reg && !reinit_pend_reg) ? ST_LOOP_CMD : ST_RST_LOW;
        end
      end
      ST_RST_LOW: begin
        if (timer_expired) state_next = ST_RST_WAIT;
      end
      ST_RST_WAIT: begin
        if (timer_expired) state_next = ST_INIT_CMD;
      end
      ST_INIT_CMD: begin
        if (i_comm_array_sent)  state_next = ST_SLP_WAIT;
        else if (timer_expired) state_next = ST_ERROR;
      end
      ST_SLP_WAIT: begin
        if (timer_expired) state_next = ST_LOOP_CMD;
      end
      ST_LOOP_CMD: begin
        if (i_comm_array_sent)  state_next = ST_PIXELS;
        else if (timer_expired) state_next = ST_ERROR;
      end
      ST_PIXELS: begin
        if (i_pix_done)         state_next = ST_FRAME_END;
        else if (timer_expired) state_next = ST_ERROR;
      end
      ST_FRAME_END: begin
        if (reinit_pend_reg) state_next = ST_RST_LOW;
        else if (i_start)    state_next = ST_LOOP_CMD;
        else                 state_next = ST_IDLE;
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Timer reload value for the state about to be entered
  always_comb begin
    state_change = (state_next != state_reg);
    timer_load   = state_change;
    case (state_next)
      ST_RST_LOW:  timer_val = LD_RST_LOW;
      ST_RST_WAIT: timer_val = LD_RST_WAIT;
      ST_SLP_WAIT: timer_val = LD_SLPOUT;
      ST_INIT_CMD,
      ST_LOOP_CMD,
      ST_PIXELS:   timer_val = LD_TIMEOUT;
      default:     timer_val = '0;
    endcase
  end

  // Init-done and pending re-init flags; entering RST_LOW restarts the whole bring-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done_reg   <= 1'b0;
      reinit_pend_reg <= 1'b0;
    end else begin
      if (state_next == ST_RST_LOW && state_reg != ST_RST_LOW) begin
        init_done_reg   <= 1'b0;
        reinit_pend_reg <= 1'b0;
      end else begin
        if (state_reg == ST_SLP_WAIT && state_next == ST_LOOP_CMD) begin
          init_done_reg <= 1'b1;
        end
        if (i_reinit) begin
          reinit_pend_reg <= 1'b1;
        end
      end
    end
  end

  // Entry marker (drives the single-cycle send pulse), frame counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_cycle_reg <= 1'b0;
      frame_cnt_reg   <= '0;
      err_reg         <= 1'b0;
    end else begin
      first_cycle_reg <= state_change;
      if (state_next == ST_FRAME_END && state_reg != ST_FRAME_END) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
      if (state_next == ST_ERROR) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Output decode from state and registers only. The command select follows the
  // array that the next send pulse will request, so it is already valid one cycle
  // before that pulse and stays put for the whole command state.
  always_comb begin
    o_lcd_rst_n     = LOW;
    o_command       = INI_COMM;
    o_send_comm_ena = 1'b0;
    o_pix_ena       = 1'b0;
    o_busy          = 1'b1;
    o_frame_done    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        o_busy      = 1'b0;
        o_lcd_rst_n = init_done_reg ? HIGH : LOW;
        o_command   = init_done_reg ? LOOP_COMM : INI_COMM;
      end
      ST_RST_LOW: begin
        o_lcd_rst_n = LOW;
      end
      ST_RST_WAIT: begin
        o_lcd_rst_n = HIGH;
      end
      ST_INIT_CMD: begin
        o_lcd_rst_n     = HIGH;
        o_send_comm_ena = first_cycle_reg;
      end
      ST_SLP_WAIT: begin
        o_lcd_rst_n = HIGH;
        o_command   = LOOP_COMM;
      end
      ST_LOOP_CMD: begin
        o_lcd_rst_n     = HIGH;
        o_command       = LOOP_COMM;
        o_send_comm_ena = first_cycle_reg;
      end
      ST_PIXELS: begin
        o_lcd_rst_n = HIGH;
        o_command   = LOOP_COMM;
        o_pix_ena   = 1'b1;
      end
      ST_FRAME_END: begin
        o_lcd_rst_n  = HIGH;
        o_command    = LOOP_COMM;
        o_frame_done = 1'b1;
      end
      ST_ERROR: begin
        o_busy      = 1'b0;
        o_lcd_rst_n = LOW;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_frame_cnt = frame_cnt_reg;
  assign o_err       = err_reg;

endmodule

// File: tb/tb_ili9341_sequencer.sv
// Self-checking bench for ili9341_sequencer with short delays.
module tb_ili9341_sequencer;

  localparam int T_RL  = 4;
  localparam int T_RW  = 6;
  localparam int T_SL  = 10;
  localparam int T_TO  = 50;
  localparam int FCW   = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_start = 1'b0;
  logic           i_reinit = 1'b0;
  logic           i_comm_array_sent = 1'b0;
  logic           i_pix_done = 1'b0;
  logic           o_lcd_rst_n;
  logic           o_send_comm_ena;
  logic           o_command;
  logic           o_pix_ena;
  logic           o_busy;
  logic           o_frame_done;
  logic [FCW-1:0] o_frame_cnt;
  logic           o_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ili9341_sequencer #(
    .T_RST_LOW_CYC  (T_RL),
    .T_RST_WAIT_CYC (T_RW),
    .T_SLPOUT_CYC   (T_SL),
    .TIMEOUT_CYC    (T_TO),
    .FCW            (FCW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_reinit          (i_reinit),
    .o_lcd_rst_n       (o_lcd_rst_n),
    .o_send_comm_ena   (o_send_comm_ena),
    .o_command         (o_command),
    .i_comm_array_sent (i_comm_array_sent),
    .o_pix_ena         (o_pix_ena),
    .i_pix_done        (i_pix_done),
    .o_busy            (o_busy),
    .o_frame_done      (o_frame_done),
    .o_frame_cnt       (o_frame_cnt),
    .o_err             (o_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the phase, the cycle it was entered and elapsed time; outputs follow
  // from the phase and "cycles since entry".
  typedef enum {M_IDLE, M_RSTL, M_RSTW, M_INIT, M_SLP, M_LOOP, M_PIX, M_FEND, M_ERR} mph_t;
  mph_t ph = M_IDLE;
  int   cyc = 0;
  int   t0 = 0;
  bit   m_init = 0;
  bit   m_reinit = 0;
  int   m_frames = 0;
  bit   m_err = 0;

  always @(posedge clk or posedge rst) begin
    mph_t nx;
    int   el;
    if (rst) begin
      ph = M_IDLE; cyc = 0; t0 = 0; m_init = 0; m_reinit = 0; m_frames = 0; m_err = 0;
    end else begin
      cyc = cyc + 1;
      el  = cyc - t0;
      nx  = ph;
      case (ph)
        M_IDLE: if (i_start) nx = (m_init && !m_reinit) ? M_LOOP : M_RSTL;
        M_RSTL: if (el == T_RL) nx = M_RSTW;
        M_RSTW: if (el == T_RW) nx = M_INIT;
        M_INIT: if (i_comm_array_sent) nx = M_SLP; else if (el == T_TO) nx = M_ERR;
        M_SLP:  if (el == T_SL) begin nx = M_LOOP; m_init = 1; end
        M_LOOP: if (i_comm_array_sent) nx = M_PIX; else if (el == T_TO) nx = M_ERR;
        M_PIX:  if (i_pix_done) nx = M_FEND; else if (el == T_TO) nx = M_ERR;
        M_FEND: if (m_reinit) nx = M_RSTL; else if (i_start) nx = M_LOOP; else nx = M_IDLE;
        default: nx = M_ERR;
      endcase
      if (nx == M_RSTL && ph != M_RSTL) begin
        m_reinit = 0;
        m_init   = 0;
      end else if (i_reinit) begin
        m_reinit = 1;
      end
      if (nx == M_FEND) m_frames = (m_frames + 1) % (1 << FCW);
      if (nx == M_ERR) m_err = 1;
      if (nx != ph) t0 = cyc;
      ph = nx;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      int e_rstn, e_cmd, e_send, e_pix, e_busy, e_fd;
      e_rstn = (ph == M_IDLE) ? int'(m_init) : (ph == M_RSTL || ph == M_ERR) ? 0 : 1;
      e_cmd  = (ph == M_SLP || ph == M_LOOP || ph == M_PIX || ph == M_FEND ||
                (ph == M_IDLE && m_init)) ? 1 : 0;
      e_send = ((ph == M_INIT || ph == M_LOOP) && cyc == t0) ? 1 : 0;
      e_pix  = (ph == M_PIX) ? 1 : 0;
      e_busy = (ph == M_IDLE || ph == M_ERR) ? 0 : 1;
      e_fd   = (ph == M_FEND) ? 1 : 0;
      chk("m_lcd_rst_n", int'(o_lcd_rst_n), e_rstn);
      chk("m_command", int'(o_command), e_cmd);
      chk("m_send_comm_ena", int'(o_send_comm_ena), e_send);
      chk("m_pix_ena", int'(o_pix_ena), e_pix);
      chk("m_busy", int'(o_busy), e_busy);
      chk("m_frame_done", int'(o_frame_done), e_fd);
      chk("m_frame_cnt", int'(o_frame_cnt), m_frames);
      chk("m_err", int'(o_err), int'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_sent;
    i_comm_array_sent = 1'b1; tick; i_comm_array_sent = 1'b0;
  endtask

  task automatic pulse_pix;
    i_pix_done = 1'b1; tick; i_pix_done = 1'b0;
  endtask

  // From the current falling edge: count low cycles of the panel reset, then
  // the high cycles before the init send pulse
  task automatic measure_reset_seq(input string tag);
    int n;
    n = 0;
    while (!o_lcd_rst_n && n < 100) begin n++; @(negedge clk); end
    chk({tag, "_rst_low_cycles"}, n, T_RL);
    n = 0;
    while (!o_send_comm_ena && n < 100) begin n++; @(negedge clk); end
    chk({tag, "_rst_wait_cycles"}, n, T_RW);
    chk({tag, "_init_cmd_sel"}, int'(o_command), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    chk_en = 1'b1;
    repeat (3) tick;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_lcd_rst_n", int'(o_lcd_rst_n), 0);
    chk("reset_command", int'(o_command), 0);
    chk("reset_frame_cnt", int'(o_frame_cnt), 0);
    chk("reset_busy", int'(o_busy), 0);

    // Bring-up: panel reset timing and init command pulse
    tick;
    i_start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_busy && n < 20) begin @(negedge clk); n++; end
    measure_reset_seq("boot");

    // Init array done -> sleep-out delay -> loop command pulse
    tick;
    pulse_sent;
    n = 0;
    @(negedge clk);
    while (!o_send_comm_ena && n < 100) begin n++; @(negedge clk); end
    chk("slpout_cycles", n, T_SL);
    chk("loop_cmd_sel", int'(o_command), 1);

    // Frame 1, with spurious handshakes outside their waiting state
    tick;
    pulse_pix;
    pulse_sent;
    repeat (10) tick;
    pulse_sent;
    repeat (8) tick;
    chk("pix_ena_mid_frame", int'(o_pix_ena), 1);
    pulse_pix;
    @(negedge clk);
    chk("frame1_done", int'(o_frame_done), 1);
    chk("frame1_cnt", int'(o_frame_cnt), 1);
    @(negedge clk);
    chk("frame1_next_loop_pulse", int'(o_send_comm_ena), 1);

    // Frame 2: start dropped mid-frame, frame still completes, then idle
    tick;
    pulse_sent;
    tick;
    i_start = 1'b0;
    repeat (5) tick;
    pulse_pix;
    @(negedge clk);
    chk("frame2_done", int'(o_frame_done), 1);
    chk("frame2_cnt", int'(o_frame_cnt), 2);
    @(negedge clk);
    chk("idle_busy", int'(o_busy), 0);
    chk("idle_lcd_rst_n", int'(o_lcd_rst_n), 1);
    repeat (3) tick;

    // Restart from idle with init done: straight to the loop array
    i_start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_send_comm_ena && n < 20) begin n++; @(negedge clk); end
    chk("restart_cmd_sel", int'(o_command), 1);
    chk("restart_lcd_rst_n", int'(o_lcd_rst_n), 1);

    // Frame 3: pixel done and reinit together -> counted, then full re-init
    tick;
    pulse_sent;
    repeat (4) tick;
    i_pix_done = 1'b1; i_reinit = 1'b1;
    tick;
    i_pix_done = 1'b0; i_reinit = 1'b0;
    @(negedge clk);
    chk("frame3_done", int'(o_frame_done), 1);
    chk("frame3_cnt", int'(o_frame_cnt), 3);
    @(negedge clk);
    measure_reset_seq("reinit");

    // No array-sent handshake -> timeout -> sticky error
    n = 0;
    while (!o_err && n < 80) begin @(negedge clk); n++; end
    chk("timeout_cycles", n, T_TO);
    chk("err_busy", int'(o_busy), 0);
    chk("err_lcd_rst_n", int'(o_lcd_rst_n), 0);
    tick;
    pulse_sent;
    repeat (5) tick;
    chk("err_sticky", int'(o_err), 1);

    // Reset out of error, then reset again in the middle of RST_WAIT
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(o_busy && o_lcd_rst_n) && n < 40) begin @(negedge clk); n++; end
    repeat (2) tick;
    rst = 1'b1;
    #1;
    chk("arst_lcd_rst_n", int'(o_lcd_rst_n), 0);
    chk("arst_command", int'(o_command), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_err", int'(o_err), 0);
    chk("arst_frame_cnt", int'(o_frame_cnt), 0);
    chk("arst_outputs", int'({o_send_comm_ena, o_pix_ena, o_frame_done}), 0);
    tick;
    i_start = 1'b0;
    rst = 1'b0;
    repeat (4) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
